// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle 8-bit shifter with a three-state sequencer.
// The accumulator is shifted by at most STEP_MAX positions per cycle until
// the effective distance is used up, then RESULT is flagged with DONE.
// Optional feature: define SHIFT_SEQ_ROR_EN to make OP=11 a rotate-right;
// without it OP=11 behaves as a logical right shift.
module shift_sequencer #(
    parameter int STEP_MAX = 7
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       START,
    input  logic [1:0] OP,
    input  logic [7:0] DATA_IN,
    input  logic [7:0] AMOUNT,
    input  logic       ABORT,
    output logic       READY,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] RESULT
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b10;
`ifdef SHIFT_SEQ_ROR_EN
    localparam logic [1:0] OP_ROR = 2'b11;
`endif
    localparam logic [3:0] STEP_LIM = 4'(STEP_MAX);

    state_e     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [3:0] rem_q, rem_d;
    logic [1:0] op_q, op_d;

    logic       accept;
    logic [3:0] eff;
    logic [3:0] step;
    logic [3:0] rem_next;
    logic [7:0] acc_shifted;

    assign accept   = (state_q == S_IDLE) && START;
    assign step     = (rem_q > STEP_LIM) ? STEP_LIM : rem_q;
    assign rem_next = rem_q - step;
    assign RESULT   = acc_q;

    // Effective distance for the request on the inputs: shifts saturate at 8,
    // a rotate only needs the distance modulo 8.
    always_comb begin
        eff = (AMOUNT > 8'd8) ? 4'd8 : AMOUNT[3:0];
`ifdef SHIFT_SEQ_ROR_EN
        if (OP == OP_ROR) begin
            eff = {1'b0, AMOUNT[2:0]};
        end
`endif
    end

    // One shift step of the accumulator using the latched operation.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        acc_shifted = acc_q >> step[2:0];
        case (op_q)
            OP_SLL:  acc_shifted = acc_q << step[2:0];
            OP_SRA:  acc_shifted = 8'($signed(acc_q) >>> step[2:0]);
`ifdef SHIFT_SEQ_ROR_EN
            OP_ROR:  acc_shifted = 8'({acc_q, acc_q} >> step[2:0]);
`endif
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: flops use non-blocking assignments so every register
            // samples the pre-edge values regardless of statement order.
            state_q <= state_d;
        end
    end

    // Next-state logic: accept from IDLE, count down in SHIFT, one cycle of DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = (eff == 4'd0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (ABORT) begin
                    state_d = S_IDLE;
                end else if (rem_next == 4'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from registered state only.
    always_comb begin
        READY = (state_q == S_IDLE);
        BUSY  = (state_q == S_SHIFT) || (state_q == S_DONE);
        DONE  = (state_q == S_DONE);
    end

    // Datapath next values: load on accept, shift while in SHIFT (also in the
    // aborting cycle, so an aborted operation leaves its partial result).
    always_comb begin
        acc_d = acc_q;
        rem_d = rem_q;
        op_d  = op_q;
        if (accept) begin
            acc_d = DATA_IN;
            op_d  = OP;
            rem_d = eff;
        end else if (state_q == S_SHIFT) begin
            acc_d = acc_shifted;
            rem_d = rem_next;
        end
    end

    // Datapath registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            acc_q <= 8'h00;
            rem_q <= 4'd0;
            op_q  <= 2'b00;
        end else begin
            acc_q <= acc_d;
            rem_q <= rem_d;
            op_q  <= op_d;
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: the stimulus process pushes the
// expected result and completion cycle of every operation that should finish;
// a monitor pops and compares whenever DONE is seen.
module tb_shift_sequencer;

    localparam int STEP_MAX = 7;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       START;
    logic [1:0] OP;
    logic [7:0] DATA_IN;
    logic [7:0] AMOUNT;
    logic       ABORT;
    logic       READY;
    logic       BUSY;
    logic       DONE;
    logic [7:0] RESULT;

    typedef struct {
        logic [7:0] result;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    shift_sequencer #(.STEP_MAX(STEP_MAX)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .START   (START),
        .OP      (OP),
        .DATA_IN (DATA_IN),
        .AMOUNT  (AMOUNT),
        .ABORT   (ABORT),
        .READY   (READY),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .RESULT  (RESULT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Effective shift distance from the operation rules.
    function automatic int ref_eff(input logic [1:0] op, input logic [7:0] amt);
`ifdef SHIFT_SEQ_ROR_EN
        if (op == 2'b11) return int'(amt) % 8;
`endif
        return (amt > 8) ? 8 : int'(amt);
    endfunction

    // Result of shifting d by n positions, built bit by bit from where each
    // output bit comes from.
    function automatic logic [7:0] ref_shift(input logic [1:0] op, input logic [7:0] d, input int n);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            case (op)
                2'b00:   r[i] = (i >= n) ? d[i - n] : 1'b0;
                2'b10:   r[i] = (i + n < 8) ? d[i + n] : d[7];
`ifdef SHIFT_SEQ_ROR_EN
                2'b11:   r[i] = d[(i + n) % 8];
`endif
                default: r[i] = (i + n < 8) ? d[i + n] : 1'b0;
            endcase
        end
        return r;
    endfunction

    function automatic int ref_latency(input int eff);
        return (eff == 0) ? 1 : (eff + STEP_MAX - 1) / STEP_MAX + 1;
    endfunction

    // Monitor: every DONE pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (RESET_N && DONE) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(DONE), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("result", 32'(RESULT), 32'(mon_e.result));
                check("done_cycle", cyc, mon_e.cyc);
            end
        end
    end

    // Issue one operation. do_abort raises ABORT in the first SHIFT cycle;
    // junk pulses START with random operands while the block is busy.
    task automatic run_op(input logic [1:0] op, input logic [7:0] d, input logic [7:0] amt,
                          input bit do_abort, input bit junk);
        int         eff;
        int         lat;
        int         waited;
        exp_t       e;
        logic [7:0] part;
        waited = 0;
        @(negedge CLK);
        while (!READY && waited < 50) begin
            @(negedge CLK);
            waited++;
        end
        if (!READY) check("ready_timeout", 32'(READY), 32'd1);
        eff     = ref_eff(op, amt);
        lat     = ref_latency(eff);
        START   = 1'b1;
        OP      = op;
        DATA_IN = d;
        AMOUNT  = amt;
        ABORT   = 1'($urandom_range(0, 1));
        if (!(do_abort && eff > 0)) begin
            e.result = ref_shift(op, d, eff);
            e.cyc    = cyc + lat;
            sb.push_back(e);
        end
        @(posedge CLK);
        #1;
        START = 1'b0;
        ABORT = 1'b0;
        if (do_abort && eff > 0) begin
            ABORT = 1'b1;
            if (junk) begin
                START   = 1'b1;
                DATA_IN = 8'($urandom);
                AMOUNT  = 8'($urandom);
            end
            @(posedge CLK);
            #1;
            ABORT = 1'b0;
            START = 1'b0;
            part  = ref_shift(op, d, (eff < STEP_MAX) ? eff : STEP_MAX);
            @(negedge CLK);
            check("abort_ready", 32'(READY), 32'd1);
            check("abort_partial", 32'(RESULT), 32'(part));
        end else begin
            if (junk) begin
                START   = 1'b1;
                OP      = 2'($urandom);
                DATA_IN = 8'($urandom);
                AMOUNT  = 8'($urandom);
                if (lat == 1) ABORT = 1'($urandom_range(0, 1));
            end
            repeat (lat) @(posedge CLK);
            #1;
            START = 1'b0;
            ABORT = 1'b0;
        end
    endtask

    initial begin
        int         waited;
        logic [1:0] op;
        logic [7:0] d;
        logic [7:0] amt;
        RESET_N = 1'b0;
        START   = 1'b0;
        OP      = 2'b00;
        DATA_IN = 8'h00;
        AMOUNT  = 8'h00;
        ABORT   = 1'b0;

        // Reset values before any clock edge.
        #2;
        check("rst_ready", 32'(READY), 32'd1);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_result", 32'(RESULT), 32'h00);
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;

        // First accept on the first edge after reset release.
        run_op(2'b00, 8'hAA, 8'd1, 1'b0, 1'b0);
        @(negedge CLK);
        check("sll_aa_1", 32'(RESULT), 32'h54);

        // SRA by 200 with START pulses while busy.
        run_op(2'b10, 8'h80, 8'd200, 1'b0, 1'b1);
        @(negedge CLK);
        check("sra_80_200", 32'(RESULT), 32'hFF);

        run_op(2'b11, 8'h81, 8'd9, 1'b0, 1'b0);
        @(negedge CLK);
`ifdef SHIFT_SEQ_ROR_EN
        check("ror_81_9", 32'(RESULT), 32'hC0);
`else
        check("op11_81_9", 32'(RESULT), 32'h00);
`endif

        run_op(2'b01, 8'hF0, 8'd0, 1'b0, 1'b0);
        @(negedge CLK);
        check("srl_f0_0", 32'(RESULT), 32'hF0);

        run_op(2'b00, 8'h01, 8'd8, 1'b1, 1'b0);
        check("sll_abort", 32'(RESULT), 32'h80);

        // ABORT alone in IDLE changes nothing.
        @(negedge CLK);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        check("idle_abort_ready", 32'(READY), 32'd1);
        check("idle_abort_result", 32'(RESULT), 32'h80);

        // Reset mid-SHIFT: outputs clear without a clock edge, no DONE follows.
        @(negedge CLK);
        START   = 1'b1;
        OP      = 2'b10;
        DATA_IN = 8'h80;
        AMOUNT  = 8'd200;
        @(posedge CLK);
        #1;
        START = 1'b0;
        #2;
        RESET_N = 1'b0;
        #1;
        check("midrst_ready", 32'(READY), 32'd1);
        check("midrst_busy", 32'(BUSY), 32'd0);
        check("midrst_done", 32'(DONE), 32'd0);
        check("midrst_result", 32'(RESULT), 32'h00);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;

        // Randomized operations.
        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            d  = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       amt = 8'($urandom_range(0, 8));
                1:       amt = 8'($urandom);
                2:       amt = 8'($urandom_range(1, 15));
                default: amt = 8'($urandom_range(8, 9));
            endcase
            run_op(op, d, amt, $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)));
        end

        // Drain the scoreboard and watch a few idle cycles for stray DONEs.
        waited = 0;
        while (sb.size() != 0 && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        repeat (5) @(negedge CLK);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
